rgb2ycbcr_packer: RTL and testbench

//  Pipelined RGB888 -> YCbCr (BT.601 studio range) converter, the encode side of ycbcr2rgb.

---
 rtl/rgb2ycbcr_packer.sv | 219 +++++++++++++++++++++
 tb/tb_rgb2ycbcr_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_packer.sv
// Purpose : RGB888 -> BT.601 studio-range YCbCr, 4:2:2 chroma averaging, pair packed to {Y0,Cb,Y1,Cr}.
// Latency : odd pixel on pixel_valid at cycle t -> word_valid at t+4 (S1, S2, S3, pack register).
// Backpr. : none; the consumer takes every word_valid pulse, and the input accepts 1 pixel/clk.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   pixel_valid       - r/g/b carry a pixel this cycle
//   line_start        - with pixel_valid: this pixel is the first (even) pixel of a line
//   r, g, b           - unsigned 8-bit components
//   word_valid        - one-cycle pulse, word holds a freshly packed pair
//   word              - {Y0[31:24], Cb[23:16], Y1[15:8], Cr[7:0]}, held between pulses
//   pair_error        - one-cycle pulse, a half pair was dropped on a mid-pair line_start
module rgb2ycbcr_packer #(
    parameter int FRAC_BITS = 11,
    parameter int Y_MIN     = 16,
    parameter int Y_MAX     = 235
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_valid,
    input  logic        line_start,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic        word_valid,
    output logic [31:0] word,
    output logic        pair_error
);

    // Coefficients scaled by 2^FRAC_BITS.
    localparam logic signed [23:0] K_YR  = 24'sd526;
    localparam logic signed [23:0] K_YG  = 24'sd1032;
    localparam logic signed [23:0] K_YB  = 24'sd201;
    localparam logic signed [23:0] K_CBR = -24'sd303;
    localparam logic signed [23:0] K_CBG = -24'sd596;
    localparam logic signed [23:0] K_CBB = 24'sd899;
    localparam logic signed [23:0] K_CRR = 24'sd899;
    localparam logic signed [23:0] K_CRG = -24'sd754;
    localparam logic signed [23:0] K_CRB = -24'sd145;

    localparam logic signed [23:0] RND   = 24'(1 << (FRAC_BITS - 1));
    localparam logic signed [23:0] LO    = 24'(Y_MIN);
    localparam logic signed [23:0] HI    = 24'(Y_MAX);
    localparam logic signed [23:0] OFF_Y = 24'sd16;
    localparam logic signed [23:0] OFF_C = 24'sd128;

    typedef enum logic {EVEN, ODD} phase_t;

    // Sum of three weighted components; 24 bits covers the worst case (+/-449k).
    function automatic logic signed [23:0] mac3(
        input logic [7:0]         x0,
        input logic [7:0]         x1,
        input logic [7:0]         x2,
        input logic signed [23:0] k0,
        input logic signed [23:0] k1,
        input logic signed [23:0] k2
    );
        logic signed [23:0] e0, e1, e2;
        e0 = $signed({16'd0, x0});
        e1 = $signed({16'd0, x1});
        e2 = $signed({16'd0, x2});
        return e0 * k0 + e1 * k1 + e2 * k2;
    endfunction

    // Round half up via arithmetic (floor) shift, add offset, clamp to studio range.
    function automatic logic [7:0] rnd_clamp(
        input logic signed [23:0] sum,
        input logic signed [23:0] off
    );
        logic signed [23:0] v;
        v = ((sum + RND) >>> FRAC_BITS) + off;
        if (v < LO) begin
            v = LO;
        end else if (v > HI) begin
            v = HI;
        end
        return v[7:0];
    endfunction

    // S1: input register
    logic               s1_vld_q, s1_vld_d;
    logic               s1_tag_q, s1_tag_d;
    logic [7:0]         s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    // S2: weighted sums
    logic               s2_vld_q, s2_vld_d;
    logic               s2_tag_q, s2_tag_d;
    logic signed [23:0] s2_y_q, s2_y_d, s2_cb_q, s2_cb_d, s2_cr_q, s2_cr_d;
    // S3: rounded, offset, clamped components
    logic               s3_vld_q, s3_vld_d;
    logic               s3_tag_q, s3_tag_d;
    logic [7:0]         s3_y_q, s3_y_d, s3_cb_q, s3_cb_d, s3_cr_q, s3_cr_d;
    // Packer
    phase_t             phase_q, phase_d;
    logic [7:0]         y0_q, y0_d, cb0_q, cb0_d, cr0_q, cr0_d;
    logic [31:0]        word_q, word_d;
    logic               word_valid_q, word_valid_d;
    logic               pair_error_q, pair_error_d;

    logic [8:0]         cb_sum, cr_sum;
    logic [7:0]         cb_avg, cr_avg;

    always_comb begin
        // Data registers only load with a valid pixel so idle cycles do not toggle them.
        s1_vld_d = pixel_valid;
        s1_tag_d = pixel_valid & line_start;
        s1_r_d   = pixel_valid ? r : s1_r_q;
        s1_g_d   = pixel_valid ? g : s1_g_q;
        s1_b_d   = pixel_valid ? b : s1_b_q;

        s2_vld_d = s1_vld_q;
        s2_tag_d = s1_tag_q;
        s2_y_d   = s1_vld_q ? mac3(s1_r_q, s1_g_q, s1_b_q, K_YR,  K_YG,  K_YB)  : s2_y_q;
        s2_cb_d  = s1_vld_q ? mac3(s1_r_q, s1_g_q, s1_b_q, K_CBR, K_CBG, K_CBB) : s2_cb_q;
        s2_cr_d  = s1_vld_q ? mac3(s1_r_q, s1_g_q, s1_b_q, K_CRR, K_CRG, K_CRB) : s2_cr_q;

        s3_vld_d = s2_vld_q;
        s3_tag_d = s2_tag_q;
        s3_y_d   = s2_vld_q ? rnd_clamp(s2_y_q,  OFF_Y) : s3_y_q;
        s3_cb_d  = s2_vld_q ? rnd_clamp(s2_cb_q, OFF_C) : s3_cb_q;
        s3_cr_d  = s2_vld_q ? rnd_clamp(s2_cr_q, OFF_C) : s3_cr_q;
    end

    // 9-bit sums cannot overflow; the shift drops the LSB after rounding up.
    always_comb begin
        cb_sum = {1'b0, cb0_q} + {1'b0, s3_cb_q} + 9'd1;
        cr_sum = {1'b0, cr0_q} + {1'b0, s3_cr_q} + 9'd1;
        cb_avg = 8'(cb_sum >> 1);
        cr_avg = 8'(cr_sum >> 1);
    end

    always_comb begin
        phase_d      = phase_q;
        y0_d         = y0_q;
        cb0_d        = cb0_q;
        cr0_d        = cr0_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        pair_error_d = 1'b0;
        // With no valid pixel the phase and latched half are simply held.
        if (s3_vld_q) begin
            case (phase_q)
                EVEN: begin
                    y0_d    = s3_y_q;
                    cb0_d   = s3_cb_q;
                    cr0_d   = s3_cr_q;
                    phase_d = ODD;
                end
                default: begin
                    if (s3_tag_q) begin
                        // New line started mid-pair: resync, this pixel becomes Y0.
                        pair_error_d = 1'b1;
                        y0_d         = s3_y_q;
                        cb0_d        = s3_cb_q;
                        cr0_d        = s3_cr_q;
                    end else begin
                        word_d       = {y0_q, cb_avg, s3_y_q, cr_avg};
                        word_valid_d = 1'b1;
                        phase_d      = EVEN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q     <= 1'b0;
            s1_tag_q     <= 1'b0;
            s1_r_q       <= '0;
            s1_g_q       <= '0;
            s1_b_q       <= '0;
            s2_vld_q     <= 1'b0;
            s2_tag_q     <= 1'b0;
            s2_y_q       <= '0;
            s2_cb_q      <= '0;
            s2_cr_q      <= '0;
            s3_vld_q     <= 1'b0;
            s3_tag_q     <= 1'b0;
            s3_y_q       <= '0;
            s3_cb_q      <= '0;
            s3_cr_q      <= '0;
            phase_q      <= EVEN;
            y0_q         <= '0;
            cb0_q        <= '0;
            cr0_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            pair_error_q <= 1'b0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_tag_q     <= s1_tag_d;
            s1_r_q       <= s1_r_d;
            s1_g_q       <= s1_g_d;
            s1_b_q       <= s1_b_d;
            s2_vld_q     <= s2_vld_d;
            s2_tag_q     <= s2_tag_d;
            s2_y_q       <= s2_y_d;
            s2_cb_q      <= s2_cb_d;
            s2_cr_q      <= s2_cr_d;
            s3_vld_q     <= s3_vld_d;
            s3_tag_q     <= s3_tag_d;
            s3_y_q       <= s3_y_d;
            s3_cb_q      <= s3_cb_d;
            s3_cr_q      <= s3_cr_d;
            phase_q      <= phase_d;
            y0_q         <= y0_d;
            cb0_q        <= cb0_d;
            cr0_q        <= cr0_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            pair_error_q <= pair_error_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;
    assign pair_error = pair_error_q;

endmodule

// File: tb/tb_rgb2ycbcr_packer.sv
// Purpose : directed self-checking bench for rgb2ycbcr_packer.
// Latency : expects words/errors 4 cycles after the pixel that completes them.
// Backpr. : none; every word_valid/pair_error pulse is captured by a negedge monitor.
module tb_rgb2ycbcr_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_valid;
    logic        line_start;
    logic [7:0]  r, g, b;
    logic        word_valid;
    logic [31:0] word;
    logic        pair_error;

    always #5 clk = ~clk;

    rgb2ycbcr_packer dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_valid(pixel_valid),
        .line_start (line_start),
        .r          (r),
        .g          (g),
        .b          (b),
        .word_valid (word_valid),
        .word       (word),
        .pair_error (pair_error)
    );

    localparam int BLK = 0;
    localparam int WHT = 1;
    localparam int RED = 2;

    // Hand-computed packed words.
    localparam logic [31:0] W_BB = 32'h1080_1080;  // black, black
    localparam logic [31:0] W_WW = 32'hEB80_EB80;  // white, white
    localparam logic [31:0] W_RB = 32'h516D_10B6;  // red, black
    localparam logic [31:0] W_BR = 32'h106D_51B6;  // black, red

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Observed pulses (monitor) and expected pulses (filled by each test).
    logic [31:0] wq[$];
    int          wcyc[$];
    int          ecyc[$];
    logic [31:0] exp_w[$];
    int          exp_wc[$];
    int          exp_ec[$];

    always @(negedge clk) begin
        if (word_valid) begin
            wq.push_back(word);
            wcyc.push_back(cyc);
        end
        if (pair_error) ecyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pix(input logic ls, input int col, output int t);
        @(negedge clk);
        pixel_valid = 1'b1;
        line_start  = ls;
        case (col)
            WHT:     begin r = 8'd255; g = 8'd255; b = 8'd255; end
            RED:     begin r = 8'd255; g = 8'd0;   b = 8'd0;   end
            default: begin r = 8'd0;   g = 8'd0;   b = 8'd0;   end
        endcase
        t = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            line_start  = 1'b0;
        end
    endtask

    task automatic clear_all();
        wq.delete();
        wcyc.delete();
        ecyc.delete();
        exp_w.delete();
        exp_wc.delete();
        exp_ec.delete();
    endtask

    task automatic compare(input string tag);
        check({tag, "_nwords"}, 32'(wq.size()), 32'(exp_w.size()));
        check({tag, "_nerrs"}, 32'(ecyc.size()), 32'(exp_ec.size()));
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), wq[i], exp_w[i]);
            check($sformatf("%s_wcyc%0d", tag, i), 32'(wcyc[i]), 32'(exp_wc[i]));
        end
        for (int i = 0; i < exp_ec.size() && i < ecyc.size(); i++) begin
            check($sformatf("%s_ecyc%0d", tag, i), 32'(ecyc[i]), 32'(exp_ec[i]));
        end
        clear_all();
    endtask

    initial begin
        int ta, tb, tc, t0;
        reset       = 1'b1;
        pixel_valid = 1'b0;
        line_start  = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word", word, 32'd0);
        check("rst_pair_error", 32'(pair_error), 32'd0);
        reset = 1'b0;
        idle(2);
        clear_all();

        // 1: black pair
        pix(1'b1, BLK, ta);
        pix(1'b0, BLK, tb);
        idle(8);
        exp_w.push_back(W_BB); exp_wc.push_back(tb + 4);
        compare("black");

        // 2: white pair, Y clamps at 235
        pix(1'b1, WHT, ta);
        pix(1'b0, WHT, tb);
        idle(8);
        exp_w.push_back(W_WW); exp_wc.push_back(tb + 4);
        compare("white");

        // 3: red then black, Cr of red clamps before averaging
        pix(1'b1, RED, ta);
        pix(1'b0, BLK, tb);
        idle(8);
        exp_w.push_back(W_RB); exp_wc.push_back(tb + 4);
        compare("red_black");

        // 4a: 8 pixels back to back
        pix(1'b1, BLK, t0);
        pix(1'b0, BLK, ta);
        pix(1'b0, WHT, ta);
        pix(1'b0, WHT, ta);
        pix(1'b0, RED, ta);
        pix(1'b0, BLK, ta);
        pix(1'b0, BLK, ta);
        pix(1'b0, RED, ta);
        idle(10);
        exp_w.push_back(W_BB); exp_wc.push_back(t0 + 5);
        exp_w.push_back(W_WW); exp_wc.push_back(t0 + 7);
        exp_w.push_back(W_RB); exp_wc.push_back(t0 + 9);
        exp_w.push_back(W_BR); exp_wc.push_back(t0 + 11);
        compare("b2b");

        // 4b: same stream with one idle cycle after every pixel
        pix(1'b1, BLK, t0); idle(1);
        pix(1'b0, BLK, ta); idle(1);
        pix(1'b0, WHT, ta); idle(1);
        pix(1'b0, WHT, ta); idle(1);
        pix(1'b0, RED, ta); idle(1);
        pix(1'b0, BLK, ta); idle(1);
        pix(1'b0, BLK, ta); idle(1);
        pix(1'b0, RED, ta);
        idle(10);
        exp_w.push_back(W_BB); exp_wc.push_back(t0 + 6);
        exp_w.push_back(W_WW); exp_wc.push_back(t0 + 10);
        exp_w.push_back(W_RB); exp_wc.push_back(t0 + 14);
        exp_w.push_back(W_BR); exp_wc.push_back(t0 + 18);
        compare("gapped");

        // 5: line_start mid-pair drops the white half, red becomes Y0
        pix(1'b1, WHT, ta);
        pix(1'b1, RED, tb);
        pix(1'b0, BLK, tc);
        idle(8);
        exp_ec.push_back(tb + 4);
        exp_w.push_back(W_RB); exp_wc.push_back(tc + 4);
        compare("resync");

        // 6: reset one cycle after the first pixel of a pair
        pix(1'b1, WHT, ta);
        @(negedge clk);
        pixel_valid = 1'b0;
        line_start  = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(8);
        compare("mid_reset");
        // No line_start: only a cleared phase makes black the Y0 here.
        pix(1'b0, BLK, ta);
        pix(1'b0, RED, tb);
        idle(8);
        exp_w.push_back(W_BR); exp_wc.push_back(tb + 4);
        compare("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
